// File: rtl/id_ex_alu_issue.sv
// -----------------------------------------------------------------------------
// id_ex_alu_issue
//
// ID/EX pipeline register and ALU issue stage. It captures the decoded
// instruction from ID, converts alu_op/funct into the 4-bit ALU control code,
// resolves the ALU operands from the registered values (and, when forwarding
// is built in, from the EX/MEM and MEM/WB result buses), and flags load-use
// hazards back to the stall logic.
//
// Build option:
//   ALU_FWD_EN  defined   -> EX/MEM and MEM/WB forwarding onto rs/rt operands.
//               undefined -> operands come straight from the ID/EX register,
//                            forward inputs are ignored, and the hazard output
//                            also stalls on any in-flight EX or EX/MEM producer.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall, flush                hold / bubble the ID/EX register (flush wins)
//   id_*                        decoded instruction fields from ID
//   exmem_*, memwb_*            forwarding sources (writer, dest, result)
//   alu_data1, alu_data2        ALU operands A and B
//   alu_ctrl                    registered ALU operation code
//   ex_store_data               forwarded rt value for stores
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
//                               registered pass-through controls
//   ex_dest                     selected destination register
//   ctrl_err                    registered illegal alu_op/funct flag
//   load_use_hazard             combinational stall request to ID
// -----------------------------------------------------------------------------
module id_ex_alu_issue #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ctrl_err,
  output logic              load_use_hazard
);

  // ALU control encodings.
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_BAD = 4'b1111;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_FUNCT = 2'b10;

  // Everything the EX stage needs, held as one register so a bubble is '0.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic [3:0]        alu_ctrl;
    logic              ctrl_err;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_t;

  ex_t ex_d, ex_q;

  logic [3:0] dec_ctrl;
  logic       dec_err;

  // ---------------------------------------------------------------------------
  // ALU control decode (in ID, captured on the edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can leave it unassigned (latch).
    dec_ctrl = CTRL_BAD;
    dec_err  = 1'b1;
    unique case (id_alu_op)
      OP_ADD: begin dec_ctrl = CTRL_ADD; dec_err = 1'b0; end
      OP_SUB: begin dec_ctrl = CTRL_SUB; dec_err = 1'b0; end
      OP_FUNCT: begin
        dec_err = 1'b0;
        case (id_funct)
          6'b100100: dec_ctrl = CTRL_AND;
          6'b100101: dec_ctrl = CTRL_OR;
          6'b100000: dec_ctrl = CTRL_ADD;
          6'b100010: dec_ctrl = CTRL_SUB;
          6'b101010: dec_ctrl = CTRL_SLT;
          6'b100111: dec_ctrl = CTRL_NOR;
          default: begin dec_ctrl = CTRL_BAD; dec_err = 1'b1; end
        endcase
      end
      default: begin dec_ctrl = CTRL_BAD; dec_err = 1'b1; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ID/EX register next state: flush beats stall beats load.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d.valid      = id_valid;
      ex_d.rs_data    = id_rs_data;
      ex_d.rt_data    = id_rt_data;
      ex_d.imm        = id_imm;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.dest       = id_reg_dst ? id_rd : id_rt;
      ex_d.alu_ctrl   = dec_ctrl;
      // An empty slot carries no instruction, so it cannot be illegal.
      ex_d.ctrl_err   = dec_err & id_valid;
      ex_d.alu_src    = id_alu_src;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.mem_to_reg = id_mem_to_reg;
    end
  end

  // NOTE: state flops use non-blocking assignments and clear asynchronously;
  // there is no memory here, so the whole register is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // ---------------------------------------------------------------------------
  // Operand resolution
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

`ifdef ALU_FWD_EN
  // The younger EX/MEM result wins over MEM/WB; register 0 is never forwarded.
  always_comb begin
    fwd_rs = ex_q.rs_data;
    if (exmem_reg_write && (exmem_rd == ex_q.rs) && (ex_q.rs != '0))
      fwd_rs = exmem_result;
    else if (memwb_reg_write && (memwb_rd == ex_q.rs) && (ex_q.rs != '0))
      fwd_rs = memwb_result;

    fwd_rt = ex_q.rt_data;
    if (exmem_reg_write && (exmem_rd == ex_q.rt) && (ex_q.rt != '0))
      fwd_rt = exmem_result;
    else if (memwb_reg_write && (memwb_rd == ex_q.rt) && (ex_q.rt != '0))
      fwd_rt = memwb_result;
  end
`else
  assign fwd_rs = ex_q.rs_data;
  assign fwd_rt = ex_q.rt_data;

  // Forward result buses have no consumer without forwarding.
  logic unused_fwd;
  assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result};
`endif

  assign alu_data1     = fwd_rs;
  assign alu_data2     = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;

  assign alu_ctrl      = ex_q.alu_ctrl;
  assign ctrl_err      = ex_q.ctrl_err;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_dest       = ex_q.dest;

  // ---------------------------------------------------------------------------
  // Load-use hazard. A bubble has valid=0, so it never raises a hazard from EX.
  // ---------------------------------------------------------------------------
  logic ex_hits_id;
  logic exmem_hits_id;

  assign ex_hits_id    = (ex_q.dest != '0) &&
                         ((ex_q.dest == id_rs) || (ex_q.dest == id_rt));
  assign exmem_hits_id = (exmem_rd != '0) &&
                         ((exmem_rd == id_rs) || (exmem_rd == id_rt));

  always_comb begin
    load_use_hazard = ex_q.valid && ex_q.mem_read && ex_hits_id;
`ifndef ALU_FWD_EN
    // Without forwarding any producer still in flight must be waited out.
    if (ex_q.valid && ex_q.reg_write && ex_hits_id) load_use_hazard = 1'b1;
    if (exmem_reg_write && exmem_hits_id)           load_use_hazard = 1'b1;
`else
    if (exmem_hits_id && 1'b0)                      load_use_hazard = 1'b1;
`endif
  end

endmodule
